// File: rtl/shift_reg_ce.sv
// WIDTH-bit clock-enabled shift register with hold/load/shift-right/shift-left modes,
// a saturating shift counter and a done flag. Define SHIFT_ROTATE_EN to add the rot port.
module shift_reg_ce #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
`ifdef SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNTW-1:0]  cnt,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHR   = 2'b10;
  localparam logic [1:0] MODE_SHL   = 2'b11;

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH);

  logic             fill_r;
  logic             fill_l;
  logic [WIDTH-1:0] q_next;
  logic [CNTW-1:0]  cnt_next;
  logic             done_next;

`ifdef SHIFT_ROTATE_EN
  assign fill_r = rot ? q[0]       : sin;
  assign fill_l = rot ? q[WIDTH-1] : sin;
`else
  assign fill_r = sin;
  assign fill_l = sin;
`endif

  // The bit that leaves on the next shift edge.
  assign sout = (mode == MODE_SHL) ? q[WIDTH-1] : q[0];

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    q_next    = q;
    cnt_next  = cnt;
    done_next = done;
    case (mode)
      MODE_HOLD: ;
      MODE_LOAD: begin
        q_next    = d;
        cnt_next  = '0;
        done_next = 1'b0;
      end
      MODE_SHR, MODE_SHL: begin
        q_next    = (mode == MODE_SHR) ? {fill_r, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill_l};
        // Counter saturates; done follows it so it is high the cycle after the WIDTH-th shift.
        cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        done_next = (cnt_next == CNT_MAX);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= INIT;
      cnt  <= '0;
      done <= 1'b0;
    end else if (ce) begin
      q    <= q_next;
      cnt  <= cnt_next;
      done <= done_next;
    end
  end

endmodule

// File: tb/tb_shift_reg_ce.sv
// Directed bench for shift_reg_ce: WIDTH=8 with INIT=8'h00 and a second instance with INIT=8'h5A.
module tb_shift_reg_ce;

  localparam int WIDTH = 8;
  localparam int CNTW  = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
`ifdef SHIFT_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q,    q2;
  logic             sout, sout2;
  logic [CNTW-1:0]  cnt,  cnt2;
  logic             done, done2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_reg_ce #(.WIDTH(WIDTH), .INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .d(d), .sin(sin),
`ifdef SHIFT_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .sout(sout), .cnt(cnt), .done(done)
  );

  shift_reg_ce #(.WIDTH(WIDTH), .INIT(8'h5A)) dut_init (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .d(d), .sin(sin),
`ifdef SHIFT_ROTATE_EN
    .rot(rot),
`endif
    .q(q2), .sout(sout2), .cnt(cnt2), .done(done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are applied 1ns after an edge; outputs are sampled 1ns after the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input int ec, input logic ed);
    check({tag, ".q"},    64'(q),    64'(eq));
    check({tag, ".cnt"},  64'(cnt),  64'(ec));
    check({tag, ".done"}, 64'(done), 64'(ed));
  endtask

  logic [7:0] exp_sout;

  initial begin
    rst = 1'b1; ce = 1'b1; mode = 2'b00; d = '0; sin = 1'b0;
`ifdef SHIFT_ROTATE_EN
    rot = 1'b0;
`endif
    // Reset: first edge with ce=1, second with ce=0.
    step();
    check_state("rst1", 8'h00, 0, 1'b0);
    check("rst1.q_init", 64'(q2), 64'h5A);
    ce = 1'b0;
    step();
    check_state("rst2", 8'h00, 0, 1'b0);
    rst = 1'b0;

    // Load, then ce=0 holds everything regardless of mode/sin.
    ce = 1'b1; mode = 2'b01; d = 8'hA5;
    step();
    check_state("load_a5", 8'hA5, 0, 1'b0);
    ce = 1'b0; mode = 2'b10; sin = 1'b1;
    repeat (3) step();
    check_state("ce_hold", 8'hA5, 0, 1'b0);

    // Mode 00 with ce=1 holds.
    ce = 1'b1; mode = 2'b00;
    step();
    check_state("mode_hold", 8'hA5, 0, 1'b0);

    // Shift right 8 times with sin=0; sout sequence 1,0,1,0,0,1,0,1.
    exp_sout = 8'hA5;
    mode = 2'b01; d = 8'hA5;
    step();
    mode = 2'b10; sin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("shr_sout%0d", i), 64'(sout), 64'(exp_sout[i]));
      step();
      if (i == 6) check_state("shr7", 8'h01, 7, 1'b0);
    end
    check_state("shr8", 8'h00, 8, 1'b1);
    repeat (2) step();
    check_state("shr_sat", 8'h00, 8, 1'b1);

    // Load while done=1 clears done on the same edge.
    mode = 2'b01; d = 8'h3C;
    step();
    check_state("load_done", 8'h3C, 0, 1'b0);

    // Load 0F, shift left once with sin=1.
    d = 8'h0F;
    step();
    mode = 2'b11; sin = 1'b1;
    #1;
    check("shl_sout", 64'(sout), 64'(1'b0));
    step();
    check_state("shl1", 8'h1F, 1, 1'b0);

    // Mid-operation reset, then first edge after release acts normally.
    mode = 2'b01; d = 8'hFF;
    step();
    mode = 2'b10; sin = 1'b0;
    repeat (4) step();
    check_state("shr4", 8'h0F, 4, 1'b0);
    rst = 1'b1;
    step();
    check_state("mid_rst", 8'h00, 0, 1'b0);
    check("mid_rst.q_init", 64'(q2), 64'h5A);
    rst = 1'b0; sin = 1'b1;
    step();
    check_state("post_rst", 8'h80, 1, 1'b0);
    check("post_rst.q_init", 64'(q2), 64'hAD);

`ifdef SHIFT_ROTATE_EN
    // Rotate left then right returns the original pattern; both count.
    mode = 2'b01; d = 8'h81; sin = 1'b0;
    step();
    rot = 1'b1; mode = 2'b11;
    step();
    check("rotl.q", 64'(q), 64'h03);
    mode = 2'b10;
    step();
    check_state("rotr", 8'h81, 2, 1'b0);
    rot = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_ce.md
Name: shift_reg_ce

Overview:
- Parametrised multi-bit successor to the single-bit clock-enabled flop.
- Holds a WIDTH-bit register with four modes (hold, parallel load, shift right, shift left), gated by a clock enable, plus a shift counter and done flag.
- Used as the operand/product register in the sequential multiplier datapath; the controller loads an operand, shifts WIDTH times and waits on done.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- INIT, 0, value q takes on reset; WIDTH bits wide.
- Derived localparam CNTW = $clog2(WIDTH+1), width of cnt.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when 0 all state holds.
- mode  input  2  00 hold, 01 load, 10 shift right, 11 shift left.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for shifts.
- rot  input  1  rotate select; port exists only when SHIFT_ROTATE_EN is defined.
- q  output  WIDTH  register contents (flop outputs).
- sout  output  1  serial output bit (combinational from q and mode).
- cnt  output  CNTW  shifts performed since last load or reset.
- done  output  1  high when cnt == WIDTH (registered).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, q<=INIT, cnt<=0, done<=0. rst overrides ce and mode.
- Reset mid-operation: the sequence aborts; the first edge after rst deasserts acts on mode normally.
- ce=0 (and rst=0): q, cnt and done all hold regardless of mode, d or sin.
- ce=1, mode 00: q, cnt and done hold.
- ce=1, mode 01: q<=d, cnt<=0, done<=0. A load always clears done, including when done=1.
- ce=1, mode 10 (shift right): q<={sin, q[WIDTH-1:1]}.
- ce=1, mode 11 (shift left): q<={q[WIDTH-2:0], sin}.
- Counter, on each ce=1 shift cycle: cnt<=cnt+1, saturating at WIDTH. done<=1 on the edge where cnt becomes WIDTH.
- Latency: done is high in the cycle immediately after the WIDTH-th shift edge.
- After done: further shifts still move data; cnt stays at WIDTH; done stays 1 until a load or reset.
- sout: q[0] when mode=10, q[WIDTH-1] when mode=11, q[0] otherwise. It shows the bit that leaves on the next shift edge.
- Single-cycle ops only: no internal state machine beyond the counter, and no pipelining. q changes exactly one edge after the commanded op.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: the rot port exists. When rot=1 during a shift, the vacated bit is filled from the outgoing bit instead of sin:
  - right: q<={q[0], q[WIDTH-1:1]}
  - left: q<={q[WIDTH-2:0], q[WIDTH-1]}
  - The counter counts rotates exactly like shifts. With rot=0, behaviour is identical to the non-rotate build.
- Not defined: no rot port; shifts always use sin.

Test Plan:
- WIDTH=8, INIT=8'h00. Assert rst for 2 cycles, including one with ce=0 -> q=8'h00, cnt=0, done=0 after the first edge.
- Load d=8'hA5 with ce=1, then ce=0 for 3 cycles with mode=10, sin=1 -> q stays 8'hA5, cnt=0.
- Load 8'hA5, then shift right 8 cycles with sin=0 -> sout sampled before each edge = 1,0,1,0,0,1,0,1; final q=8'h00, cnt=8; done=0 after the 7th edge and 1 after the 8th. Two more shifts -> cnt stays 8, done stays 1.
- Load 8'h0F, then shift left once with sin=1 -> sout=0 before the edge; q=8'h1F and cnt=1 after it. With done=1, load 8'h3C -> q=8'h3C, cnt=0, done=0 on the same edge.
- Load 8'hFF, shift right 4 cycles (cnt=4), assert rst on the next edge with mode=10 -> q=INIT, cnt=0, done=0. Rerun with INIT=8'h5A -> q=8'h5A.
- SHIFT_ROTATE_EN defined: load 8'h81, rot=1, shift left once -> q=8'h03; shift right once -> q=8'h81; cnt=2.
